// File: rtl/psram_xfer_sched.sv
// ---------------------------------------------------------------------------
// psram_xfer_sched
//
// Request scheduler in front of the PSRAM core. Single-byte read/write
// requests are buffered in a small FIFO and issued to the core one at a time.
// Each transfer is a one-cycle xfer_en pulse. Address, data and direction stay
// stable until the next issue. The scheduler then waits for the core's done
// strobe or for a programmable timeout. It returns the result on a
// valid/ready response channel. A programmable idle gap (CE recovery) is
// inserted after every response before the next issue.
//
// Ports
//   clk_i, rst_n_i           clock, synchronous active-low reset
//   cfg_tmo_i                transfer timeout in cycles (0 = disabled)
//   cfg_gap_i                idle cycles after each response handshake
//   req_valid_i/ready_o      request handshake; ready = FIFO not full
//   req_we_i/addr_i/wdata_i  request payload
//   rsp_valid_o/ready_i      response handshake
//   rsp_rdata_o, rsp_err_o   read byte (0 for writes/errors), timeout flag
//   xfer_en_o                one-cycle start pulse to the core
//   xfer_we/addr/wdata_o     transfer attributes to the core
//   xfer_done_i, rdata_i     core completion strobe and read byte
//   busy_o                   FSM active or requests pending
//   fifo_cnt_o               request FIFO occupancy
// ---------------------------------------------------------------------------
module psram_xfer_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int TMO_WIDTH  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [TMO_WIDTH-1:0]          cfg_tmo_i,
    input  logic [7:0]                    cfg_gap_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic                          req_we_i,
    input  logic [31:0]                   req_addr_i,
    input  logic [7:0]                    req_wdata_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [7:0]                    rsp_rdata_o,
    output logic                          rsp_err_o,
    output logic                          xfer_en_o,
    output logic                          xfer_we_o,
    output logic [31:0]                   xfer_addr_o,
    output logic [7:0]                    xfer_wdata_o,
    input  logic                          xfer_done_i,
    input  logic [7:0]                    xfer_rdata_i,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_GAP
    } state_t;

    // ------------------------------------------------------------------
    // Request FIFO. Entry layout: {we, addr[31:0], wdata[7:0]}
    // ------------------------------------------------------------------
    logic [40:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             push;
    logic             pop;

    state_t           state_q;

    // Ready depends only on the registered count, so a pop in the same
    // cycle never combinationally opens the request port.
    assign req_ready_o = (cnt_q != FULL_CNT);
    assign push        = req_valid_i && req_ready_o;
    assign pop         = (state_q == S_IDLE) && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage has no reset so it maps onto RAM; only the pointers are cleared.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_we_i, req_addr_i, req_wdata_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Transfer FSM with registered outputs
    // ------------------------------------------------------------------
    logic                 xfer_en_q;
    logic                 xfer_we_q;
    logic [31:0]          xfer_addr_q;
    logic [7:0]           xfer_wdata_q;
    logic                 rsp_valid_q;
    logic [7:0]           rsp_rdata_q;
    logic                 rsp_err_q;
    logic [TMO_WIDTH-1:0] tmo_cnt_q;
    logic [7:0]           gap_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            xfer_en_q    <= 1'b0;
            xfer_we_q    <= 1'b0;
            xfer_addr_q  <= '0;
            xfer_wdata_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            tmo_cnt_q    <= '0;
            gap_cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        // Registered read of the FIFO head
                        {xfer_we_q, xfer_addr_q, xfer_wdata_q} <= mem_q[rd_ptr_q];
                        xfer_en_q <= 1'b1;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    xfer_en_q <= 1'b0;
                    tmo_cnt_q <= '0;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    // Done takes priority over a coincident timeout
                    if (xfer_done_i) begin
                        rsp_rdata_q <= xfer_we_q ? 8'h00 : xfer_rdata_i;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if ((cfg_tmo_i != '0) &&
                                 (tmo_cnt_q == cfg_tmo_i - 1'b1)) begin
                        rsp_rdata_q <= 8'h00;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        if (cfg_gap_i == 8'd0) begin
                            state_q <= S_IDLE;
                        end else begin
                            // Count of cfg_gap_i cycles spent in GAP
                            gap_cnt_q <= cfg_gap_i - 8'd1;
                            state_q   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == 8'd0) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign xfer_en_o    = xfer_en_q;
    assign xfer_we_o    = xfer_we_q;
    assign xfer_addr_o  = xfer_addr_q;
    assign xfer_wdata_o = xfer_wdata_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_o  = rsp_rdata_q;
    assign rsp_err_o    = rsp_err_q;
    assign busy_o       = (state_q != S_IDLE) || (cnt_q != '0);
    assign fifo_cnt_o   = cnt_q;

endmodule

// File: tb/tb_psram_xfer_sched.sv
// ---------------------------------------------------------------------------
// tb_psram_xfer_sched
//
// Directed self-checking bench for psram_xfer_sched. The PSRAM core is
// played by hand: each step drives xfer_done_i/xfer_rdata_i at a chosen
// cycle and checks the scheduler's outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_psram_xfer_sched;

    localparam int FIFO_DEPTH = 4;
    localparam int TMO_WIDTH  = 16;

    logic                  clk_i = 1'b0;
    logic                  rst_n_i;
    logic [TMO_WIDTH-1:0]  cfg_tmo_i;
    logic [7:0]            cfg_gap_i;
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [31:0]           req_addr_i;
    logic [7:0]            req_wdata_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [7:0]            rsp_rdata_o;
    logic                  rsp_err_o;
    logic                  xfer_en_o;
    logic                  xfer_we_o;
    logic [31:0]           xfer_addr_o;
    logic [7:0]            xfer_wdata_o;
    logic                  xfer_done_i;
    logic [7:0]            xfer_rdata_i;
    logic                  busy_o;
    logic [2:0]            fifo_cnt_o;

    always #5 clk_i = ~clk_i;

    psram_xfer_sched #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .TMO_WIDTH  (TMO_WIDTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .cfg_tmo_i    (cfg_tmo_i),
        .cfg_gap_i    (cfg_gap_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .xfer_en_o    (xfer_en_o),
        .xfer_we_o    (xfer_we_o),
        .xfer_addr_o  (xfer_addr_o),
        .xfer_wdata_o (xfer_wdata_o),
        .xfer_done_i  (xfer_done_i),
        .xfer_rdata_i (xfer_rdata_i),
        .busy_o       (busy_o),
        .fifo_cnt_o   (fifo_cnt_o)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    int         en_cnt = 0;
    logic [8:0] rsp_log [$];

    // Mid-cycle monitor: count start pulses, log {err, rdata} of every
    // response handshake that the next rising edge will complete.
    always @(negedge clk_i) begin
        if (xfer_en_o) en_cnt++;
        if (rsp_valid_o && rsp_ready_i) rsp_log.push_back({rsp_err_o, rsp_rdata_o});
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_en(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles && !xfer_en_o; i++) tick();
        chk(tag, {31'd0, xfer_en_o}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0;
        int en0;

        rst_n_i      = 1'b0;
        cfg_tmo_i    = '0;
        cfg_gap_i    = '0;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_addr_i   = '0;
        req_wdata_i  = '0;
        rsp_ready_i  = 1'b0;
        xfer_done_i  = 1'b0;
        xfer_rdata_i = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_xfer_en",   {31'd0, xfer_en_o},   32'd0);
        chk("rst_busy",      {31'd0, busy_o},      32'd0);
        chk("rst_fifo_cnt",  {29'd0, fifo_cnt_o},  32'd0);
        chk("rst_xfer_addr", xfer_addr_o,          32'd0);
        chk("rst_rsp_err",   {31'd0, rsp_err_o},   32'd0);
        rst_n_i = 1'b1;
        tick();

        // ---------------- single write ----------------
        en0 = en_cnt;
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h10; req_wdata_i = 8'hA5;
        tick();                                 // accepted at edge N
        req_valid_i = 1'b0;
        chk("wr_fifo_cnt", {29'd0, fifo_cnt_o}, 32'd1);
        chk("wr_en_n",     {31'd0, xfer_en_o},  32'd0);
        chk("wr_busy",     {31'd0, busy_o},     32'd1);
        tick();                                 // edge N+1: ISSUE
        chk("wr_en",       {31'd0, xfer_en_o},  32'd1);
        chk("wr_addr",     xfer_addr_o,         32'h10);
        chk("wr_wdata",    {24'd0, xfer_wdata_o}, 32'hA5);
        chk("wr_we",       {31'd0, xfer_we_o},  32'd1);
        chk("wr_fifo_0",   {29'd0, fifo_cnt_o}, 32'd0);
        repeat (5) tick();
        chk("wr_no_rsp",   {31'd0, rsp_valid_o}, 32'd0);
        xfer_rdata_i = 8'hFF;                   // must not leak into a write response
        xfer_done_i = 1'b1;
        tick();                                 // done 6 cycles after xfer_en edge
        xfer_done_i = 1'b0;
        chk("wr_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("wr_rsp_rdata", {24'd0, rsp_rdata_o}, 32'h00);
        chk("wr_rsp_err",   {31'd0, rsp_err_o},   32'd0);
        chk("wr_en_pulses", en_cnt - en0,         32'd1);
        chk("wr_addr_hold", xfer_addr_o,          32'h10);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("wr_rsp_drop",  {31'd0, rsp_valid_o}, 32'd0);
        chk("wr_idle",      {31'd0, busy_o},      32'd0);

        // ---------------- read then read ----------------
        l0 = rsp_log.size();
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h20;
        tick();
        req_addr_i = 32'h21;
        tick();                                 // push + pop same edge
        req_valid_i = 1'b0;
        chk("rr_en1",     {31'd0, xfer_en_o},  32'd1);
        chk("rr_addr1",   xfer_addr_o,         32'h20);
        chk("rr_fifo",    {29'd0, fifo_cnt_o}, 32'd1);
        tick();                                 // WAIT
        xfer_rdata_i = 8'h3C; xfer_done_i = 1'b1;
        tick();                                 // edge D
        xfer_done_i = 1'b0;
        chk("rr_rsp1",    {23'd0, rsp_valid_o, rsp_rdata_o}, {23'd0, 1'b1, 8'h3C});
        tick();                                 // D+1: handshake
        chk("rr_rsp1_drop", {31'd0, rsp_valid_o}, 32'd0);
        chk("rr_en_gap",  {31'd0, xfer_en_o},  32'd0);
        tick();                                 // D+2: next issue
        chk("rr_en2",     {31'd0, xfer_en_o},  32'd1);
        chk("rr_addr2",   xfer_addr_o,         32'h21);
        tick();
        xfer_rdata_i = 8'hC3; xfer_done_i = 1'b1;
        tick();
        xfer_done_i = 1'b0;
        chk("rr_rsp2",    {23'd0, rsp_valid_o, rsp_rdata_o}, {23'd0, 1'b1, 8'hC3});
        tick();
        chk("rr_log_n",   rsp_log.size() - l0, 32'd2);
        chk("rr_log0",    {23'd0, rsp_log[l0]},     {23'd0, 9'h03C});
        chk("rr_log1",    {23'd0, rsp_log[l0 + 1]}, {23'd0, 9'h0C3});

        // ---------------- FIFO fill ----------------
        l0  = rsp_log.size();
        en0 = en_cnt;
        req_we_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_valid_i = 1'b1;
            req_addr_i  = 32'h40 + 32'(i);
            tick();
        end
        req_addr_i = 32'h45;                    // 6th request, must stall
        chk("fill_ready", {31'd0, req_ready_o}, 32'd0);
        chk("fill_cnt",   {29'd0, fifo_cnt_o},  32'd4);
        repeat (3) tick();
        chk("fill_hold_cnt",   {29'd0, fifo_cnt_o},  32'd4);
        chk("fill_hold_ready", {31'd0, req_ready_o}, 32'd0);
        chk("fill_one_issued", en_cnt - en0,         32'd1);
        req_valid_i = 1'b0;
        chk("fill_addr0", xfer_addr_o, 32'h40);
        xfer_rdata_i = 8'h50; xfer_done_i = 1'b1;
        tick();
        xfer_done_i = 1'b0;
        for (int i = 1; i < 5; i++) begin
            wait_en("fill_en", 10);
            chk("fill_addr", xfer_addr_o, 32'h40 + 32'(i));
            tick();
            xfer_rdata_i = 8'h50 + 8'(i); xfer_done_i = 1'b1;
            tick();
            xfer_done_i = 1'b0;
        end
        tick();
        chk("fill_log_n", rsp_log.size() - l0, 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("fill_order", {23'd0, rsp_log[l0 + i]}, {23'd0, 1'b0, 8'h50 + 8'(i)});
        end
        chk("fill_idle",  {31'd0, busy_o}, 32'd0);

        // ---------------- timeout ----------------
        rsp_ready_i  = 1'b0;
        cfg_tmo_i    = 16'd10;
        xfer_rdata_i = 8'hEE;
        req_valid_i = 1'b1; req_addr_i = 32'h60;
        tick();
        req_valid_i = 1'b0;
        tick();                                 // ISSUE
        chk("tmo_en", {31'd0, xfer_en_o}, 32'd1);
        tick();                                 // edge E: WAIT entered
        repeat (9) tick();
        chk("tmo_early", {31'd0, rsp_valid_o}, 32'd0);
        tick();                                 // E+10
        chk("tmo_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("tmo_err",   {31'd0, rsp_err_o},   32'd1);
        chk("tmo_rdata", {24'd0, rsp_rdata_o}, 32'd0);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;

        // done in the 10th WAIT cycle beats the timeout
        req_valid_i = 1'b1; req_addr_i = 32'h61;
        tick();
        req_valid_i = 1'b0;
        tick();
        tick();                                 // edge E
        repeat (9) tick();
        chk("race_early", {31'd0, rsp_valid_o}, 32'd0);
        xfer_rdata_i = 8'h77; xfer_done_i = 1'b1;
        tick();
        xfer_done_i = 1'b0;
        chk("race_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("race_err",   {31'd0, rsp_err_o},   32'd0);
        chk("race_rdata", {24'd0, rsp_rdata_o}, 32'h77);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        cfg_tmo_i = '0;

        // ---------------- gap and backpressure ----------------
        cfg_gap_i = 8'd3;
        req_valid_i = 1'b1; req_addr_i = 32'h70;
        tick();
        req_addr_i = 32'h71;
        tick();                                 // ISSUE first
        req_valid_i = 1'b0;
        tick();                                 // WAIT
        xfer_rdata_i = 8'h11; xfer_done_i = 1'b1;
        tick();                                 // RESP
        xfer_done_i = 1'b0;
        xfer_rdata_i = 8'h99;                   // core bus changes; response must not
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold", {23'd0, rsp_valid_o, rsp_rdata_o}, {23'd0, 1'b1, 8'h11});
        end
        rsp_ready_i = 1'b1;
        tick();                                 // handshake H
        rsp_ready_i = 1'b0;
        chk("gap_rsp_drop", {31'd0, rsp_valid_o}, 32'd0);
        chk("gap_busy",     {31'd0, busy_o},      32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gap_quiet", {31'd0, xfer_en_o}, 32'd0);
        end
        tick();                                 // H+4
        chk("gap_en",   {31'd0, xfer_en_o}, 32'd1);
        chk("gap_addr", xfer_addr_o,        32'h71);
        tick();
        xfer_rdata_i = 8'h22; xfer_done_i = 1'b1;
        tick();
        xfer_done_i = 1'b0;
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        repeat (4) tick();
        chk("gap_idle", {31'd0, busy_o}, 32'd0);
        cfg_gap_i = 8'd0;

        // ---------------- reset mid-WAIT ----------------
        l0  = rsp_log.size();
        en0 = en_cnt;
        for (int i = 0; i < 3; i++) begin
            req_valid_i = 1'b1;
            req_addr_i  = 32'h90 + 32'(i);
            tick();
        end
        req_valid_i = 1'b0;
        chk("rw_queued", {29'd0, fifo_cnt_o}, 32'd2);
        tick();
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        chk("rw_cnt",   {29'd0, fifo_cnt_o},  32'd0);
        chk("rw_busy",  {31'd0, busy_o},      32'd0);
        chk("rw_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rw_addr",  xfer_addr_o,          32'd0);
        rsp_ready_i = 1'b1;
        xfer_rdata_i = 8'h99; xfer_done_i = 1'b1;   // late done from the core
        tick();
        xfer_done_i = 1'b0;
        repeat (3) tick();
        chk("rw_no_rsp",  {31'd0, rsp_valid_o}, 32'd0);
        chk("rw_log",     rsp_log.size() - l0,  32'd0);
        chk("rw_busy2",   {31'd0, busy_o},      32'd0);
        chk("rw_en_once", en_cnt - en0,         32'd1);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h80; req_wdata_i = 8'h5A;
        tick();
        req_valid_i = 1'b0;
        wait_en("rw_new_en", 5);
        chk("rw_new_addr", xfer_addr_o,            32'h80);
        chk("rw_new_wd",   {24'd0, xfer_wdata_o},  32'h5A);
        chk("rw_new_we",   {31'd0, xfer_we_o},     32'd1);
        tick();
        xfer_done_i = 1'b1;
        tick();
        xfer_done_i = 1'b0;
        chk("rw_new_rsp",  {22'd0, rsp_valid_o, rsp_err_o, rsp_rdata_o}, {22'd0, 2'b10, 8'h00});
        tick();
        chk("rw_new_log",  rsp_log.size() - l0, 32'd1);
        rsp_ready_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
